stamp_request_arbiter: RTL and testbench

//  Round-robin arbiter sharing one timestamp-record sink among NUM_REQ command sources.

---
 rtl/profcounter_pkg.sv | 16 +
 rtl/rr_priority_pick.sv | 34 +++
 rtl/stamp_request_arbiter.sv | 165 ++++++++++++++++
 tb/tb_stamp_request_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/profcounter_pkg.sv
// Shared command encodings and FSM state type for the profiling-counter record path.
package profcounter_pkg;

    localparam int CMD_W = 4;

    localparam logic [CMD_W-1:0] CMD_STAMP = 4'h1;
    localparam logic [CMD_W-1:0] CMD_STOP  = 4'h2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        FINISH
    } state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set bit of req_i at or above ptr_i, wrapping.
// Returns a one-hot grant, its index, and whether anything was requesting.
module rr_priority_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        int pos;
        // NOTE: every output gets a default first so no path through the loop infers a latch.
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        pos     = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr_i) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!any_o && req_i[pos[IDX_W-1:0]]) begin
                any_o                     = 1'b1;
                grant_o[pos[IDX_W-1:0]]   = 1'b1;
                idx_o                     = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/stamp_request_arbiter.sv
// Round-robin arbiter merging per-source STAMP records into one registered stream,
// absorbing per-source STOPs and emitting a single merged STOP at the end of a run.
module stamp_request_arbiter
    import profcounter_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  DATA_W  = 64,
    parameter int  CMD_W   = profcounter_pkg::CMD_W,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic                      start,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*CMD_W-1:0]  req_cmd,
    input  logic [NUM_REQ*DATA_W-1:0] req_value,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CMD_W-1:0]          out_cmd,
    output logic [DATA_W-1:0]         out_value,
    output logic [ID_W-1:0]           out_id,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               stamp_cnt
);

    state_e              state_q;
    logic [NUM_REQ-1:0]  stopped_q;
    logic [ID_W-1:0]     ptr_q;
    logic                out_valid_q;
    logic [CMD_W-1:0]    out_cmd_q;
    logic [DATA_W-1:0]   out_value_q;
    logic [ID_W-1:0]     out_id_q;
    logic                busy_q;
    logic                done_q;
    logic [31:0]         stamp_cnt_q;

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_any;
    logic                slot_free;
    logic                accept;
    logic                grant_stopped;
    logic                fwd_stamp;
    logic                is_stop;
    logic [ID_W-1:0]     ptr_d;
    logic [CMD_W-1:0]    sel_cmd;
    logic [DATA_W-1:0]   sel_value;

    rr_priority_pick #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    // out_ready feeds req_ready combinationally so a drain and a refill share one cycle.
    assign slot_free = !out_valid_q || out_ready;
    assign accept    = (state_q == RUN) && slot_free && grant_any;
    assign req_ready = accept ? grant : '0;

    always_comb begin
        sel_cmd   = '0;
        sel_value = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_cmd   = req_cmd[i*CMD_W +: CMD_W];
                sel_value = req_value[i*DATA_W +: DATA_W];
            end
        end
    end

    // Records from a source that already stopped are swallowed, STAMPs included.
    assign grant_stopped = |(stopped_q & grant);
    assign fwd_stamp     = accept && (sel_cmd == CMD_W'(CMD_STAMP)) && !grant_stopped;
    assign is_stop       = accept && (sel_cmd == CMD_W'(CMD_STOP));
    assign ptr_d         = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= IDLE;
            stopped_q   <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_cmd_q   <= '0;
            out_value_q <= '0;
            out_id_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stamp_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;

            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (accept) begin
                ptr_q <= ptr_d;
                if (fwd_stamp) begin
                    out_valid_q <= 1'b1;
                    out_cmd_q   <= sel_cmd;
                    out_value_q <= sel_value;
                    out_id_q    <= grant_idx;
                    stamp_cnt_q <= stamp_cnt_q + 32'd1;
                end
                if (is_stop) begin
                    stopped_q <= stopped_q | grant;
                end
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= RUN;
                        busy_q      <= 1'b1;
                        stopped_q   <= '0;
                        stamp_cnt_q <= '0;
                        ptr_q       <= '0;
                    end
                end
                RUN: begin
                    if ((&stopped_q) && !out_valid_q) begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Wait out any record still sitting in the slot before the merged STOP.
                    if (slot_free) begin
                        out_valid_q <= 1'b1;
                        out_cmd_q   <= CMD_W'(CMD_STOP);
                        out_value_q <= '0;
                        out_id_q    <= '0;
                        state_q     <= FINISH;
                    end
                end
                FINISH: begin
                    if (out_valid_q && out_ready) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_cmd   = out_cmd_q;
    assign out_value = out_value_q;
    assign out_id    = out_id_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign stamp_cnt = stamp_cnt_q;

endmodule

// File: tb/tb_stamp_request_arbiter.sv
// Directed bench for stamp_request_arbiter: per-source stimulus queues feed the DUT and
// an expected-output queue is popped and compared on every output handshake.
module tb_stamp_request_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 64;
    localparam int CMD_W   = 4;
    localparam int ID_W    = 2;

    localparam logic [CMD_W-1:0] C_STAMP = 4'h1;
    localparam logic [CMD_W-1:0] C_STOP  = 4'h2;
    localparam logic [CMD_W-1:0] C_BAD   = 4'h7;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] value;
    } rec_t;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] value;
        logic [ID_W-1:0]   id;
    } exp_t;

    logic                      ap_clk = 1'b0;
    logic                      ap_rst;
    logic                      start;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*CMD_W-1:0]  req_cmd;
    logic [NUM_REQ*DATA_W-1:0] req_value;
    logic                      out_valid;
    logic                      out_ready;
    logic [CMD_W-1:0]          out_cmd;
    logic [DATA_W-1:0]         out_value;
    logic [ID_W-1:0]           out_id;
    logic                      busy;
    logic                      done;
    logic [31:0]               stamp_cnt;

    rec_t src_q [NUM_REQ][$];
    exp_t exp_q [$];
    int   grant_log [$];
    int   t2_exp_grants [4] = '{1, 2, 1, 1};

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    logic               s_out_valid;
    logic [DATA_W-1:0]  s_out_value;
    logic [ID_W-1:0]    s_out_id;
    logic [NUM_REQ-1:0] s_req_ready;
    logic               s_busy;
    logic               s_done;
    logic [31:0]        s_stamp_cnt;

    always #5 ap_clk = ~ap_clk;

    stamp_request_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .CMD_W   (CMD_W)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .start     (start),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_value (req_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cmd   (out_cmd),
        .out_value (out_value),
        .out_id    (out_id),
        .busy      (busy),
        .done      (done),
        .stamp_cnt (stamp_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_src(input int i, input logic [CMD_W-1:0] c, input logic [DATA_W-1:0] v);
        rec_t r;
        r.cmd   = c;
        r.value = v;
        src_q[i].push_back(r);
    endtask

    task automatic push_exp(input logic [CMD_W-1:0] c, input logic [DATA_W-1:0] v,
                            input logic [ID_W-1:0] id);
        exp_t e;
        e.cmd   = c;
        e.value = v;
        e.id    = id;
        exp_q.push_back(e);
    endtask

    function automatic bit src_empty();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drive_heads();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_q[i].size() != 0) begin
                req_valid[i]                  = 1'b1;
                req_cmd[i*CMD_W +: CMD_W]     = src_q[i][0].cmd;
                req_value[i*DATA_W +: DATA_W] = src_q[i][0].value;
            end else begin
                req_valid[i]                  = 1'b0;
                req_cmd[i*CMD_W +: CMD_W]     = '0;
                req_value[i*DATA_W +: DATA_W] = '0;
            end
        end
    endtask

    // One clock: sample at the falling edge, score any handshake, then advance the sources.
    task automatic step();
        logic [NUM_REQ-1:0] acc;
        exp_t               e;
        @(negedge ap_clk);
        s_out_valid = out_valid;
        s_out_value = out_value;
        s_out_id    = out_id;
        s_req_ready = req_ready;
        s_busy      = busy;
        s_done      = done;
        s_stamp_cnt = stamp_cnt;
        acc         = req_valid & req_ready;
        if (done) done_cnt++;
        check("req_ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
        if (out_valid && out_ready) begin
            check("out_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_cmd", 64'(out_cmd), 64'(e.cmd));
                check("out_value", out_value, e.value);
                check("out_id", 64'(out_id), 64'(e.id));
            end
        end
        @(posedge ap_clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i]) begin
                grant_log.push_back(i);
                void'(src_q[i].pop_front());
            end
        end
        drive_heads();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((!src_empty() || exp_q.size() != 0) && n < 60) begin
            step();
            n++;
        end
        check(tag, 64'(src_empty() && exp_q.size() == 0), 64'd1);
    endtask

    initial begin
        int n;
        ap_rst    = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        req_valid = '0;
        req_cmd   = '0;
        req_value = '0;
        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        step();
        check("rst_out_valid", 64'(s_out_valid), 64'd0);
        check("rst_busy", 64'(s_busy), 64'd0);
        check("rst_done", 64'(s_done), 64'd0);
        check("rst_req_ready", 64'(s_req_ready), 64'd0);
        check("rst_stamp_cnt", 64'(s_stamp_cnt), 64'd0);

        // 1: all four sources present a STAMP together; back-to-back in id order.
        push_src(0, C_STAMP, 64'h10);
        push_src(1, C_STAMP, 64'h20);
        push_src(2, C_STAMP, 64'h30);
        push_src(3, C_STAMP, 64'h40);
        push_exp(C_STAMP, 64'h10, 2'd0);
        push_exp(C_STAMP, 64'h20, 2'd1);
        push_exp(C_STAMP, 64'h30, 2'd2);
        push_exp(C_STAMP, 64'h40, 2'd3);
        start = 1'b1;
        drive_heads();
        step();
        start = 1'b0;
        n = 1;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        check("t1_cycles", 64'(n), 64'd6);
        check("t1_busy", 64'(s_busy), 64'd1);
        check("t1_stamp_cnt", 64'(s_stamp_cnt), 64'd4);

        // 2: source 1 streams, source 2 offers one record; it must be served next.
        grant_log.delete();
        push_src(1, C_STAMP, 64'hA1);
        push_src(1, C_STAMP, 64'hA2);
        push_src(1, C_STAMP, 64'hA3);
        push_src(2, C_STAMP, 64'hB2);
        push_exp(C_STAMP, 64'hA1, 2'd1);
        push_exp(C_STAMP, 64'hB2, 2'd2);
        push_exp(C_STAMP, 64'hA2, 2'd1);
        push_exp(C_STAMP, 64'hA3, 2'd1);
        drive_heads();
        drain("t2_drain");
        check("t2_grant_count", 64'(grant_log.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            check("t2_grant_order", 64'(grant_log[k]), 64'(t2_exp_grants[k]));
        end
        check("t2_stamp_cnt", 64'(s_stamp_cnt), 64'd8);

        // 3: sink stalls for five cycles with a record held.
        out_ready = 1'b0;
        push_src(0, C_STAMP, 64'hC1);
        push_src(0, C_STAMP, 64'hC2);
        push_exp(C_STAMP, 64'hC1, 2'd0);
        push_exp(C_STAMP, 64'hC2, 2'd0);
        drive_heads();
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            check("t3_hold_valid", 64'(s_out_valid), 64'd1);
            check("t3_hold_value", s_out_value, 64'hC1);
            check("t3_hold_id", 64'(s_out_id), 64'd0);
            check("t3_hold_ready", 64'(s_req_ready), 64'd0);
        end
        out_ready = 1'b1;
        step();
        check("t3_release_ready", 64'(s_req_ready), 64'b0001);
        check("t3_release_left", 64'(exp_q.size()), 64'd1);
        step();
        check("t3_next_left", 64'(exp_q.size()), 64'd0);
        check("t3_stamp_cnt", 64'(s_stamp_cnt), 64'd10);

        // 4: STOPs arrive from 3,0,2,1 interleaved with STAMPs; one merged STOP at the end.
        done_cnt = 0;
        push_src(3, C_STOP, 64'h0);
        drive_heads();
        drain("t4_stop3");
        push_src(0, C_STAMP, 64'hD0);
        push_src(0, C_STOP, 64'h0);
        push_exp(C_STAMP, 64'hD0, 2'd0);
        drive_heads();
        drain("t4_stop0");
        push_src(2, C_STOP, 64'h0);
        drive_heads();
        drain("t4_stop2");
        step();
        step();
        check("t4_no_early_valid", 64'(s_out_valid), 64'd0);
        check("t4_busy_mid", 64'(s_busy), 64'd1);
        check("t4_no_early_done", 64'(done_cnt), 64'd0);
        push_src(1, C_STAMP, 64'hD1);
        push_src(1, C_STOP, 64'h0);
        push_exp(C_STAMP, 64'hD1, 2'd1);
        push_exp(C_STOP, 64'h0, 2'd0);
        drive_heads();
        drain("t4_final_stop");
        check("t4_done_before_end", 64'(done_cnt), 64'd0);
        step();
        check("t4_done_pulse", 64'(s_done), 64'd1);
        check("t4_busy_fall", 64'(s_busy), 64'd0);
        step();
        check("t4_done_clear", 64'(s_done), 64'd0);
        check("t4_done_count", 64'(done_cnt), 64'd1);
        check("t4_stamp_cnt", 64'(s_stamp_cnt), 64'd12);

        // 5: new run; unknown command and STAMP after STOP are swallowed; mid-run start ignored.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("t5_cnt_cleared", 64'(s_stamp_cnt), 64'd0);
        check("t5_busy", 64'(s_busy), 64'd1);
        push_src(1, C_STAMP, 64'hE1);
        push_exp(C_STAMP, 64'hE1, 2'd1);
        drive_heads();
        drain("t5_stamp");
        check("t5_stamp_cnt", 64'(s_stamp_cnt), 64'd1);
        push_src(2, C_STOP, 64'h0);
        push_src(2, C_BAD, 64'h77);
        push_src(2, C_STAMP, 64'h99);
        drive_heads();
        drain("t5_swallow");
        step();
        step();
        check("t5_no_out", 64'(s_out_valid), 64'd0);
        check("t5_cnt_unchanged", 64'(s_stamp_cnt), 64'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("t5_start_ignored_cnt", 64'(s_stamp_cnt), 64'd1);
        check("t5_start_ignored_busy", 64'(s_busy), 64'd1);

        // 6: reset while a record is held, then a clean run.
        out_ready = 1'b0;
        push_src(0, C_STAMP, 64'hF0);
        drive_heads();
        drain("t6_load");
        step();
        check("t6_held_valid", 64'(s_out_valid), 64'd1);
        check("t6_held_value", s_out_value, 64'hF0);
        done_cnt = 0;
        ap_rst   = 1'b1;
        step();
        ap_rst    = 1'b0;
        out_ready = 1'b1;
        step();
        check("t6_rst_valid", 64'(s_out_valid), 64'd0);
        check("t6_rst_busy", 64'(s_busy), 64'd0);
        check("t6_rst_done", 64'(s_done), 64'd0);
        step();
        check("t6_rst_no_done", 64'(done_cnt), 64'd0);
        check("t6_rst_no_out", 64'(s_out_valid), 64'd0);

        start = 1'b1;
        step();
        start = 1'b0;
        push_src(3, C_STAMP, 64'h33);
        push_src(1, C_STAMP, 64'h11);
        push_exp(C_STAMP, 64'h11, 2'd1);
        push_exp(C_STAMP, 64'h33, 2'd3);
        drive_heads();
        drain("t6_run_stamps");
        for (int i = 0; i < NUM_REQ; i++) begin
            push_src(i, C_STOP, 64'h0);
        end
        push_exp(C_STOP, 64'h0, 2'd0);
        drive_heads();
        drain("t6_run_stop");
        step();
        check("t6_run_done", 64'(s_done), 64'd1);
        check("t6_run_busy", 64'(s_busy), 64'd0);
        check("t6_run_stamp_cnt", 64'(s_stamp_cnt), 64'd2);
        check("t6_run_done_count", 64'(done_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
